// File: rtl/decode_control_pipe_pkg.sv
// Shared decode constants, ID/EX control bundle and the opcode decode table.
// Used by decode_control_pipe and its hazard unit (see CTRL_HAZARD_DETECT_EN).
package decode_control_pipe_pkg;

   localparam int NB_OP_C        = 6;
   localparam int NB_FUNCT_C     = 6;
   localparam int NB_REG_C       = 5;
   localparam int NB_SIZE_TYPE_C = 3;
   localparam int NB_ALUOP_C     = 4;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_LH    = 6'h21;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_LBU   = 6'h24;
   localparam logic [5:0] OP_LHU   = 6'h25;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_HALT  = 6'h3F;
   localparam logic [5:0] FN_JR    = 6'h08;

   localparam logic [3:0] ALU_OP_ADD   = 4'd0;
   localparam logic [3:0] ALU_OP_SUB   = 4'd1;
   localparam logic [3:0] ALU_OP_AND   = 4'd2;
   localparam logic [3:0] ALU_OP_OR    = 4'd3;
   localparam logic [3:0] ALU_OP_XOR   = 4'd4;
   localparam logic [3:0] ALU_OP_SLT   = 4'd5;
   localparam logic [3:0] ALU_OP_LUI   = 4'd6;
   localparam logic [3:0] ALU_OP_RTYPE = 4'd7;

   localparam logic [1:0] EXT_SIGNED   = 2'b00;
   localparam logic [1:0] EXT_UNSIGNED = 2'b01;
   localparam logic [1:0] EXT_LUI      = 2'b10;

   localparam logic [2:0] SIZE_WORD  = 3'b000;
   localparam logic [2:0] SIZE_HALF  = 3'b001;
   localparam logic [2:0] SIZE_BYTE  = 3'b010;
   localparam logic [2:0] SIZE_HALFU = 3'b101;
   localparam logic [2:0] SIZE_BYTEU = 3'b110;

   localparam logic [1:0] REG_DST_RT  = 2'b00;
   localparam logic [1:0] REG_DST_RD  = 2'b01;
   localparam logic [1:0] REG_DST_R31 = 2'b10;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   typedef struct packed {
      logic       valid;
      logic       alu_src;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       mem_to_reg;
      logic [1:0] reg_dst;
      logic       branch;
      logic       branch_ne;
      logic       jump;
      logic       jump_reg;
      logic [1:0] ext_mode;
      logic [2:0] word_size;
      logic [3:0] alu_op;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

   // Unknown opcodes (and HALT) fall through to a bubble.
   function automatic ctrl_t decode_ctrl(
      input logic [NB_OP_C-1:0]    op,
      input logic [NB_FUNCT_C-1:0] funct
   );
      ctrl_t c;
      c       = CTRL_BUBBLE;
      c.valid = 1'b1;
      case (op)
         OP_RTYPE: begin
            c.reg_dst = REG_DST_RD;
            c.alu_op  = ALU_OP_RTYPE;
            if (funct == FN_JR) c.jump_reg = 1'b1;
            else                c.reg_write = 1'b1;
         end
         OP_ADDI, OP_SLTI, OP_ANDI,
         OP_ORI, OP_XORI, OP_LUI: begin
            c.alu_src   = 1'b1;
            c.reg_write = 1'b1;
            case (op)
               OP_SLTI: c.alu_op = ALU_OP_SLT;
               OP_ANDI: c.alu_op = ALU_OP_AND;
               OP_ORI:  c.alu_op = ALU_OP_OR;
               OP_XORI: c.alu_op = ALU_OP_XOR;
               OP_LUI:  c.alu_op = ALU_OP_LUI;
               default: c.alu_op = ALU_OP_ADD;
            endcase
            if (op == OP_LUI)
               c.ext_mode = EXT_LUI;
            else if (op inside {OP_ANDI, OP_ORI, OP_XORI})
               c.ext_mode = EXT_UNSIGNED;
         end
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
            c.alu_src    = 1'b1;
            c.mem_read   = 1'b1;
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
            case (op)
               OP_LB:   c.word_size = SIZE_BYTE;
               OP_LH:   c.word_size = SIZE_HALF;
               OP_LBU:  c.word_size = SIZE_BYTEU;
               OP_LHU:  c.word_size = SIZE_HALFU;
               default: c.word_size = SIZE_WORD;
            endcase
         end
         OP_SB, OP_SH, OP_SW: begin
            c.alu_src   = 1'b1;
            c.mem_write = 1'b1;
            case (op)
               OP_SB:   c.word_size = SIZE_BYTE;
               OP_SH:   c.word_size = SIZE_HALF;
               default: c.word_size = SIZE_WORD;
            endcase
         end
         OP_BEQ, OP_BNE: begin
            c.branch    = 1'b1;
            c.branch_ne = (op == OP_BNE);
            c.alu_op    = ALU_OP_SUB;
         end
         OP_J:   c.jump = 1'b1;
         OP_JAL: begin
            c.jump      = 1'b1;
            c.reg_dst   = REG_DST_R31;
            c.reg_write = 1'b1;
         end
         default: c = CTRL_BUBBLE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/decode_control_pipe_hazard_detect_unit.sv
// Combinational load-use hazard compare between the ID instruction and an EX load.
// Instantiated by decode_control_pipe only when CTRL_HAZARD_DETECT_EN is defined.
module decode_control_pipe_hazard_detect_unit
   import decode_control_pipe_pkg::*;
#(
   parameter int NB_REG = NB_REG_C
) (
   input  logic              i_valid,
   input  logic              i_ex_mem_read,
   input  logic [NB_REG-1:0] i_ex_rt,
   input  logic [NB_REG-1:0] i_rs,
   input  logic [NB_REG-1:0] i_rt,
   output logic              o_hazard
);

   logic w_rt_live;
   logic w_match;

   // r0 is hardwired zero, so a load into it never creates a dependency.
   assign w_rt_live = (i_ex_rt != '0);
   assign w_match   = (i_ex_rt == i_rs) | (i_ex_rt == i_rt);
   assign o_hazard  = i_valid & i_ex_mem_read & w_rt_live & w_match;

endmodule

// File: rtl/decode_control_pipe.sv
// Registered decode stage: control decode, bubbles, debug-step gating and HALT FSM.
// Define CTRL_HAZARD_DETECT_EN to enable load-use stall detection.
module decode_control_pipe
   import decode_control_pipe_pkg::*;
#(
   parameter int NB_OP        = NB_OP_C,
   parameter int NB_FUNCT     = NB_FUNCT_C,
   parameter int NB_REG       = NB_REG_C,
   parameter int NB_SIZE_TYPE = NB_SIZE_TYPE_C,
   parameter int NB_ALUOP     = NB_ALUOP_C
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   input  logic                    i_enable,
   input  logic                    i_valid,
   input  logic [NB_OP-1:0]        i_opcode,
   input  logic [NB_FUNCT-1:0]     i_funct,
   input  logic [NB_REG-1:0]       i_rs,
   input  logic [NB_REG-1:0]       i_rt,
   input  logic                    i_ex_mem_read,
   input  logic [NB_REG-1:0]       i_ex_rt,
   input  logic                    i_flush,
   output logic                    o_stall,
   output logic                    o_valid,
   output logic                    o_alu_src,
   output logic                    o_mem_read,
   output logic                    o_mem_write,
   output logic                    o_reg_write,
   output logic                    o_mem_to_reg,
   output logic [1:0]              o_reg_dst,
   output logic                    o_branch,
   output logic                    o_branch_ne,
   output logic                    o_jump,
   output logic                    o_jump_reg,
   output logic [1:0]              o_ext_mode,
   output logic [NB_SIZE_TYPE-1:0] o_word_size,
   output logic [NB_ALUOP-1:0]     o_alu_op,
   output logic                    o_halted
);

   state_t r_state;
   state_t w_state_next;
   ctrl_t  r_ctrl;
   ctrl_t  w_ctrl_next;
   logic   w_hazard;
   logic   w_halted;

`ifdef CTRL_HAZARD_DETECT_EN
   decode_control_pipe_hazard_detect_unit #(
      .NB_REG (NB_REG)
   ) u_hazard (
      .i_valid       (i_valid),
      .i_ex_mem_read (i_ex_mem_read),
      .i_ex_rt       (i_ex_rt),
      .i_rs          (i_rs),
      .i_rt          (i_rt),
      .o_hazard      (w_hazard)
   );
`else
   logic w_unused_hz;
   assign w_unused_hz = ^{i_ex_mem_read, i_ex_rt, i_rs, i_rt};
   assign w_hazard    = 1'b0;
`endif

   assign w_halted = (r_state == ST_HALTED);
   // A resolving flush squashes ID, so it also cancels the load-use stall.
   assign o_stall  = w_halted | (w_hazard & ~i_flush);

   always_comb begin
      w_state_next = r_state;
      w_ctrl_next  = r_ctrl;
      if (i_enable) begin
         w_ctrl_next = CTRL_BUBBLE;
         if (!w_halted && !i_flush && !w_hazard && i_valid) begin
            if (i_opcode == OP_HALT)
               w_state_next = ST_HALTED;
            else
               w_ctrl_next = decode_ctrl(i_opcode, i_funct);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= ST_RUN;
         r_ctrl  <= CTRL_BUBBLE;
      end else begin
         r_state <= w_state_next;
         r_ctrl  <= w_ctrl_next;
      end
   end

   assign o_valid      = r_ctrl.valid;
   assign o_alu_src    = r_ctrl.alu_src;
   assign o_mem_read   = r_ctrl.mem_read;
   assign o_mem_write  = r_ctrl.mem_write;
   assign o_reg_write  = r_ctrl.reg_write;
   assign o_mem_to_reg = r_ctrl.mem_to_reg;
   assign o_reg_dst    = r_ctrl.reg_dst;
   assign o_branch     = r_ctrl.branch;
   assign o_branch_ne  = r_ctrl.branch_ne;
   assign o_jump       = r_ctrl.jump;
   assign o_jump_reg   = r_ctrl.jump_reg;
   assign o_ext_mode   = r_ctrl.ext_mode;
   assign o_word_size  = r_ctrl.word_size;
   assign o_alu_op     = r_ctrl.alu_op;
   assign o_halted     = w_halted;

endmodule

// File: tb/tb_decode_control_pipe.sv
// Randomized bench for decode_control_pipe against an in-bench behavioural model.
// Follows CTRL_HAZARD_DETECT_EN the same way the design does.
module tb_decode_control_pipe;

`ifdef CTRL_HAZARD_DETECT_EN
   localparam bit HZ = 1'b1;
`else
   localparam bit HZ = 1'b0;
`endif

   logic       i_clk = 1'b0;
   logic       i_reset_n;
   logic       i_enable, i_valid, i_flush, i_ex_mem_read;
   logic [5:0] i_opcode, i_funct;
   logic [4:0] i_rs, i_rt, i_ex_rt;
   logic       o_stall, o_valid, o_alu_src, o_mem_read, o_mem_write;
   logic       o_reg_write, o_mem_to_reg, o_branch, o_branch_ne;
   logic       o_jump, o_jump_reg, o_halted;
   logic [1:0] o_reg_dst, o_ext_mode;
   logic [2:0] o_word_size;
   logic [3:0] o_alu_op;

   int n_pass = 0;
   int n_tot  = 0;

   logic [20:0] m_out;
   bit          m_halt;

   always #5 i_clk = ~i_clk;

   decode_control_pipe dut (
      .i_clk         (i_clk),
      .i_reset_n     (i_reset_n),
      .i_enable      (i_enable),
      .i_valid       (i_valid),
      .i_opcode      (i_opcode),
      .i_funct       (i_funct),
      .i_rs          (i_rs),
      .i_rt          (i_rt),
      .i_ex_mem_read (i_ex_mem_read),
      .i_ex_rt       (i_ex_rt),
      .i_flush       (i_flush),
      .o_stall       (o_stall),
      .o_valid       (o_valid),
      .o_alu_src     (o_alu_src),
      .o_mem_read    (o_mem_read),
      .o_mem_write   (o_mem_write),
      .o_reg_write   (o_reg_write),
      .o_mem_to_reg  (o_mem_to_reg),
      .o_reg_dst     (o_reg_dst),
      .o_branch      (o_branch),
      .o_branch_ne   (o_branch_ne),
      .o_jump        (o_jump),
      .o_jump_reg    (o_jump_reg),
      .o_ext_mode    (o_ext_mode),
      .o_word_size   (o_word_size),
      .o_alu_op      (o_alu_op),
      .o_halted      (o_halted)
   );

   function automatic logic [20:0] got();
      return {o_valid, o_alu_src, o_mem_read, o_mem_write, o_reg_write,
              o_mem_to_reg, o_reg_dst, o_branch, o_branch_ne, o_jump,
              o_jump_reg, o_ext_mode, o_word_size, o_alu_op};
   endfunction

   // Expected bundle from instruction classes, same field order as got().
   function automatic logic [20:0] model(input logic [5:0] op,
                                         input logic [5:0] fn);
      bit ld, st, imm, r, jr, br, jmp, jal;
      logic [1:0] rdst, ext, sz;
      logic [3:0] aop;
      logic [2:0] ws;
      ld  = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
      st  = op inside {6'h28, 6'h29, 6'h2B};
      imm = op inside {6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
      r   = (op == 6'h00);
      jr  = r && (fn == 6'h08);
      br  = (op == 6'h04) || (op == 6'h05);
      jal = (op == 6'h03);
      jmp = (op == 6'h02) || jal;
      if (!(ld || st || imm || r || br || jmp)) return '0;
      rdst = r ? 2'b01 : (jal ? 2'b10 : 2'b00);
      ext  = (op inside {6'h0C, 6'h0D, 6'h0E}) ? 2'b01 :
             (op == 6'h0F) ? 2'b10 : 2'b00;
      sz   = (op[1:0] == 2'b00) ? 2'b10 : (op[1:0] == 2'b01) ? 2'b01 : 2'b00;
      ws   = (ld || st) ? {ld && op[2], sz} : 3'b000;
      aop  = r ? 4'd7 : br ? 4'd1 :
             (op == 6'h0A) ? 4'd5 : (op == 6'h0C) ? 4'd2 :
             (op == 6'h0D) ? 4'd3 : (op == 6'h0E) ? 4'd4 :
             (op == 6'h0F) ? 4'd6 : 4'd0;
      return {1'b1, ld || st || imm, ld, st,
              (r && !jr) || imm || ld || jal, ld, rdst,
              br, op == 6'h05, jmp, jr, ext, ws, aop};
   endfunction

   task automatic chk(input string name, input logic [31:0] g,
                      input logic [31:0] e);
      n_tot++;
      if (g === e) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, g, e, $time);
   endtask

   task automatic step(input bit en, input bit v, input bit fl,
                       input bit exmr, input logic [5:0] op,
                       input logic [5:0] fn, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] ert);
      bit hz;
      i_enable = en; i_valid = v; i_flush = fl; i_ex_mem_read = exmr;
      i_opcode = op; i_funct = fn; i_rs = rs; i_rt = rt; i_ex_rt = ert;
      #1;
      hz = HZ && v && exmr && (ert != 0) && (ert == rs || ert == rt);
      chk("stall", {31'b0, o_stall}, {31'b0, m_halt || (hz && !fl)});
      if (en) begin
         if (m_halt || fl || hz || !v) m_out = '0;
         else if (op == 6'h3F) begin m_out = '0; m_halt = 1'b1; end
         else m_out = model(op, fn);
      end
      @(posedge i_clk); #1;
      chk("bundle", {11'b0, got()}, {11'b0, m_out});
      chk("halted", {31'b0, o_halted}, {31'b0, m_halt});
   endtask

   task automatic do_reset();
      #2;
      i_reset_n = 1'b0;
      #1;
      m_out = '0; m_halt = 1'b0;
      chk("rst_bundle", {11'b0, got()}, 32'h0);
      chk("rst_halted", {31'b0, o_halted}, 32'h0);
      #1;
      i_reset_n = 1'b1;
   endtask

   initial begin
      logic [5:0] ops [20];
      logic [5:0] op;
      ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A,
              6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h24,
              6'h25, 6'h28, 6'h29, 6'h2B};
      m_out = '0; m_halt = 1'b0;
      i_reset_n = 1'b0; i_enable = 1'b0; i_valid = 1'b0; i_flush = 1'b0;
      i_ex_mem_read = 1'b0; i_opcode = '0; i_funct = '0;
      i_rs = '0; i_rt = '0; i_ex_rt = '0;
      #2;
      chk("por_bundle", {11'b0, got()}, 32'h0);
      chk("por_halted", {31'b0, o_halted}, 32'h0);
      @(posedge i_clk); #1;
      i_reset_n = 1'b1;

      // LW launch, then reset mid-run, then LW again after release
      step(1, 1, 0, 0, 6'h23, 6'h00, 5'd1, 5'd2, 5'd0);
      chk("lw_lit", {11'b0, got()}, 32'h1D8000);
      i_opcode = 6'h23; i_valid = 1'b1;
      do_reset();
      step(1, 1, 0, 0, 6'h23, 6'h00, 5'd1, 5'd2, 5'd0);
      chk("lw_after_rst", {31'b0, o_mem_read & o_mem_to_reg}, 32'h1);

      // load-use: rt=5 stalls (when enabled), rt=0 never does
      step(1, 1, 0, 1, 6'h00, 6'h20, 5'd5, 5'd3, 5'd5);
      chk("lu_bubble", {31'b0, o_valid}, {31'b0, !HZ});
      step(1, 1, 0, 1, 6'h00, 6'h20, 5'd0, 5'd3, 5'd0);
      chk("add_lit", {11'b0, got()}, 32'h112007);

      // flush wins over stall
      step(1, 1, 1, 1, 6'h00, 6'h20, 5'd5, 5'd5, 5'd5);
      chk("flush_bubble", {11'b0, got()}, 32'h0);

      // debug step hold then release
      step(1, 1, 0, 0, 6'h00, 6'h20, 5'd1, 5'd2, 5'd0);
      step(0, 1, 0, 0, 6'h08, 6'h00, 5'd1, 5'd2, 5'd0);
      chk("hold_add", {11'b0, got()}, 32'h112007);
      step(1, 1, 0, 0, 6'h08, 6'h00, 5'd1, 5'd2, 5'd0);
      chk("addi_lit", {11'b0, got()}, 32'h190000);

      // HALT sticks until reset
      step(1, 1, 0, 0, 6'h3F, 6'h00, 5'd1, 5'd2, 5'd0);
      chk("halt_flag", {31'b0, o_halted}, 32'h1);
      step(1, 1, 0, 0, 6'h00, 6'h20, 5'd1, 5'd2, 5'd0);
      chk("halt_stall", {31'b0, o_stall}, 32'h1);
      chk("halt_bubble", {31'b0, o_valid}, 32'h0);
      do_reset();

      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 39) == 0) do_reset();
         op = ($urandom_range(0, 9) == 0) ? 6'($urandom) :
              ops[$urandom_range(0, 19)];
         if ($urandom_range(0, 49) == 0) op = 6'h3F;
         step($urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
              op, ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)));
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
